// File: rtl/fnd_defs.sv
// rtl/fnd_defs.sv - shared constants and state encoding for the FND source sequencer
//   BCD_BLANK   : digit code that drives every FND segment off
//   fnd_state_e : sequencer states SHOW / BLANK
package fnd_defs;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } fnd_state_e;

endpackage

// File: rtl/fnd_next_src.sv
// rtl/fnd_next_src.sv - rotate-priority search for the next enabled source above the current one
//   i_cur   : currently shown source
//   i_en    : per-source enable mask
//   o_next  : first enabled source after i_cur, wrapping N_SRC-1 -> 0
//   o_found : 1 when some source other than i_cur is enabled
module fnd_next_src #(
  parameter int N_SRC = 4,
  localparam int W_SRC = $clog2(N_SRC)
) (
  input  logic [W_SRC-1:0] i_cur,
  input  logic [N_SRC-1:0] i_en,
  output logic [W_SRC-1:0] o_next,
  output logic             o_found
);

  // Walk offsets from farthest to nearest so the nearest enabled source wins.
  // Offset 0 (the current source) is never a candidate.
  always_comb begin
    int w_idx;
    o_found = 1'b0;
    o_next  = i_cur;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      w_idx = (int'(i_cur) + k) % N_SRC;
      if (i_en[w_idx]) begin
        o_found = 1'b1;
        o_next  = W_SRC'(w_idx);
      end
    end
  end

endmodule

// File: rtl/fnd_src_seq.sv
// rtl/fnd_src_seq.sv - selects one of N_SRC BCD sources for an FND controller, blanking on source change
//   clk, reset : rising-edge clock, synchronous active-high reset
//   i_bcd      : flattened BCD, slice (src*PAGES+page), digit 0 at LSB
//   i_sel      : manual source select
//   i_page     : page select
//   i_auto     : 1 = rotate on i_tick, 0 = follow i_sel
//   i_tick     : single-cycle rotate strobe
//   i_src_en   : per-source enable mask
//   o_bcd      : registered BCD digits
//   o_src      : currently shown source
//   o_blank    : high while blanking
module fnd_src_seq #(
  parameter int N_SRC     = 4,
  parameter int PAGES     = 2,
  parameter int DIGITS    = 4,
  parameter int BLANK_CYC = 3,
  localparam int W_SRC = $clog2(N_SRC),
  localparam int W_PG  = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int W_OUT = DIGITS * 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SRC*PAGES*DIGITS*4-1:0] i_bcd,
  input  logic [W_SRC-1:0]               i_sel,
  input  logic [W_PG-1:0]                i_page,
  input  logic                           i_auto,
  input  logic                           i_tick,
  input  logic [N_SRC-1:0]               i_src_en,
  output logic [W_OUT-1:0]               o_bcd,
  output logic [W_SRC-1:0]               o_src,
  output logic                           o_blank
);

  import fnd_defs::*;

  // Counter is loaded with BLANK_CYC-1 and the switch happens when it reads 0,
  // giving exactly BLANK_CYC blank cycles.
  localparam logic [7:0] CNT_LOAD = 8'(BLANK_CYC - 1);

  fnd_state_e       r_state;
  logic [W_SRC-1:0] r_src;
  logic [W_SRC-1:0] r_target;
  logic [7:0]       r_cnt;
  logic [W_OUT-1:0] r_bcd;

  fnd_state_e       w_state_d;
  logic [W_SRC-1:0] w_src_d;
  logic [W_SRC-1:0] w_target_d;
  logic [7:0]       w_cnt_d;
  logic [W_OUT-1:0] w_bcd_d;

  logic [W_SRC-1:0] w_nxt;
  logic             w_nxt_found;
  logic             w_sel_ok;
  logic             w_man_req;
  logic             w_retarget;
  logic             w_auto_req;

  fnd_next_src #(.N_SRC(N_SRC)) u_next_src (
    .i_cur   (r_src),
    .i_en    (i_src_en),
    .o_next  (w_nxt),
    .o_found (w_nxt_found)
  );

  // Manual selection must be in range and point at an enabled source.
  assign w_sel_ok   = (32'(i_sel) < 32'(N_SRC)) && i_src_en[i_sel];
  assign w_man_req  = !i_auto && w_sel_ok && (i_sel != r_src);
  // During BLANK only a third source restarts the switch; re-selecting the
  // pending target or the source still latched in o_src is a no-op.
  assign w_retarget = !i_auto && w_sel_ok && (i_sel != r_src) && (i_sel != r_target);
  assign w_auto_req = i_auto && i_tick && w_nxt_found;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SHOW;
      r_src    <= '0;
      r_target <= '0;
      r_cnt    <= '0;
      r_bcd    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_src    <= w_src_d;
      r_target <= w_target_d;
      r_cnt    <= w_cnt_d;
      r_bcd    <= w_bcd_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_src_d    = r_src;
    w_target_d = r_target;
    w_cnt_d    = r_cnt;
    if (r_state == SHOW) begin
      if (w_auto_req) begin
        w_state_d  = BLANK;
        w_target_d = w_nxt;
        w_cnt_d    = CNT_LOAD;
      end else if (w_man_req) begin
        w_state_d  = BLANK;
        w_target_d = i_sel;
        w_cnt_d    = CNT_LOAD;
      end
    end else begin
      // Ticks arriving here are dropped on purpose.
      if (w_retarget) begin
        w_target_d = i_sel;
        w_cnt_d    = CNT_LOAD;
      end else if (r_cnt == 8'd0) begin
        w_state_d = SHOW;
        w_src_d   = r_target;
      end else begin
        w_cnt_d = r_cnt - 8'd1;
      end
    end
  end

  // o_bcd is fetched for the source that will be shown after this edge, so the
  // new source's digits appear in the same cycle o_src changes.
  always_comb begin
    int w_slice;
    w_slice = int'(w_src_d) * PAGES + ((PAGES > 1) ? int'(i_page) : 0);
    if (w_state_d == BLANK) begin
      w_bcd_d = {DIGITS{BCD_BLANK}};
    end else begin
      w_bcd_d = i_bcd[w_slice*W_OUT +: W_OUT];
    end
    o_blank = (r_state == BLANK);
    o_src   = r_src;
    o_bcd   = r_bcd;
  end

endmodule
